multicycle_control_fsm: RTL and testbench

- Main control state machine for the multi-cycle MIPS datapath. It sits directly upstream of the ALU.
- Decodes opcode/funct from the instruction register and sequences fetch/decode/execute/memory/writeback.
- Drives the 3-bit ALU operation code and all datapath mux selects and write strobes. Consumes the ALU zero flag for branch resolution.
- Stalls on a memory-ready handshake.

---
 rtl/multicycle_control_fsm.sv | 260 ++++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multi-cycle MIPS datapath: fetch/decode/execute/memory/writeback sequencing.
// Optional `BNE_SUPPORT_EN adds bne (opcode 0x05) via a latched branch_ne flag; default build treats 0x05 as illegal.
module multicycle_control_fsm #(
  parameter logic [3:0] RESET_STATE      = 4'd0,
  parameter bit         ILLEGAL_TO_FETCH = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       is_zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_operations,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal_instr
);

  // state   | meaning
  // IDLE    | post-reset, all outputs low, goes to FETCH
  // FETCH   | read instruction at PC, PC+4, wait for mem_ready
  // DECODE  | branch target into ALUOut, dispatch on opcode
  // MEMADR  | compute load/store address
  // MEMRD   | load access, wait for mem_ready
  // MEMWB   | write MDR into rt
  // MEMWR   | store access, wait for mem_ready
  // EXECUTE | R-type ALU operation
  // ALUWB   | write ALUOut into rd
  // BRANCH  | compare regA/regB, conditional PC load
  // ADDIEX  | regA + sign-extended immediate
  // ADDIWB  | write ALUOut into rt
  // JUMP    | load jump target
  // HALT    | locked after illegal instruction until reset
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    EXECUTE = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    JUMP    = 4'd12,
    HALT    = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e state_q, state_d;
  logic   store_flag_q, store_flag_d;
  logic   branch_ne;
  logic   bne_en;
  logic [2:0] funct_op;
  logic       funct_shift;
  logic       funct_legal;
  state_e     illegal_next;

  assign illegal_next = ILLEGAL_TO_FETCH ? FETCH : HALT;

`ifdef BNE_SUPPORT_EN
  logic branch_ne_q, branch_ne_d;

  always_comb begin
    branch_ne_d = branch_ne_q;
    if (state_q == DECODE) begin
      if (opcode == OP_BNE)      branch_ne_d = 1'b1;
      else if (opcode == OP_BEQ) branch_ne_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) branch_ne_q <= 1'b0;
    else        branch_ne_q <= branch_ne_d;
  end

  assign branch_ne = branch_ne_q;
  assign bne_en    = 1'b1;
`else
  assign branch_ne = 1'b0;
  assign bne_en    = 1'b0;
`endif

  always_comb begin
    funct_op    = ALU_AND;
    funct_shift = 1'b0;
    funct_legal = 1'b1;
    case (funct)
      6'h20: funct_op = ALU_ADD;
      6'h22: funct_op = ALU_SUB;
      6'h24: funct_op = ALU_AND;
      6'h25: funct_op = ALU_OR;
      6'h27: funct_op = ALU_NOR;
      6'h2A: funct_op = ALU_SLT;
      6'h00: begin funct_op = ALU_SLL; funct_shift = 1'b1; end
      6'h02: begin funct_op = ALU_SRL; funct_shift = 1'b1; end
      default: funct_legal = 1'b0;
    endcase
  end

  assign store_flag_d = (state_q == DECODE) ? (opcode == OP_SW) : store_flag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= state_e'(RESET_STATE);
      store_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_flag_q <= store_flag_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    i_or_d         = 1'b0;
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    pc_src         = 2'b00;
    alu_src_a      = 2'b00;
    alu_src_b      = 2'b00;
    alu_operations = 3'b000;
    reg_write      = 1'b0;
    reg_dst        = 1'b0;
    mem_to_reg     = 1'b0;
    instr_done     = 1'b0;
    illegal_instr  = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_read       = 1'b1;
        alu_src_b      = 2'b01;
        alu_operations = ALU_ADD;
        ir_write       = mem_ready;
        pc_write       = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_b      = 2'b11;
        alu_operations = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            if (bne_en && opcode == OP_BNE) begin
              state_d = BRANCH;
            end else begin
              illegal_instr = 1'b1;
              instr_done    = 1'b1;
              state_d       = illegal_next;
            end
          end
        endcase
      end
      MEMADR: begin
        alu_src_a      = 2'b01;
        alu_src_b      = 2'b10;
        alu_operations = ALU_ADD;
        state_d        = store_flag_q ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = FETCH;
      end
      EXECUTE: begin
        alu_src_a = funct_shift ? 2'b10 : 2'b01;
        if (funct_legal) begin
          alu_operations = funct_op;
          state_d        = ALUWB;
        end else begin
          illegal_instr = 1'b1;
          instr_done    = 1'b1;
          state_d       = illegal_next;
        end
      end
      // funct is held in the IR, so re-decoding keeps ALUOut's inputs stable
      ALUWB: begin
        alu_src_a      = funct_shift ? 2'b10 : 2'b01;
        alu_operations = funct_op;
        reg_write      = 1'b1;
        reg_dst        = 1'b1;
        instr_done     = 1'b1;
        state_d        = FETCH;
      end
      BRANCH: begin
        alu_src_a      = 2'b01;
        alu_operations = ALU_SUB;
        pc_src         = 2'b01;
        pc_write       = is_zero ^ branch_ne;
        instr_done     = 1'b1;
        state_d        = FETCH;
      end
      ADDIEX: begin
        alu_src_a      = 2'b01;
        alu_src_b      = 2'b10;
        alu_operations = ALU_ADD;
        state_d        = ADDIWB;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: per-instruction expected output sequences built from the ISA rules, randomized stalls/inputs.
module tb_multicycle_control_fsm;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h20;
  logic       is_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_a, alu_src_b;
  logic [2:0] alu_operations;
  logic       reg_write, reg_dst, mem_to_reg, instr_done, illegal_instr;

  int n_checks = 0;
  int n_fail = 0;

  logic [18:0] exp_q[$];
  logic [18:0] obs_q[$];
  bit          mr_q[$];
  logic [18:0] obs_vec;

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .is_zero(is_zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_operations(alu_operations), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  assign obs_vec = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
                    alu_src_b, alu_operations, reg_write, reg_dst, mem_to_reg, instr_done,
                    illegal_instr};

`ifdef BNE_SUPPORT_EN
  localparam bit BNE = 1'b1;
`else
  localparam bit BNE = 1'b0;
`endif

  function automatic logic [18:0] ov(input bit mrd, mwr, iod, irw, pcw,
                                     input logic [1:0] pcs, sa, sb, input logic [2:0] op,
                                     input bit rw, rd, m2r, done, ill);
    return {mrd, mwr, iod, irw, pcw, pcs, sa, sb, op, rw, rd, m2r, done, ill};
  endfunction

  function automatic void push(input logic [18:0] v, input bit mr);
    exp_q.push_back(v);
    mr_q.push_back(mr);
  endfunction

  function automatic bit rnd_bit();
    return bit'($urandom_range(0, 1));
  endfunction

  // ALU function table for R-type instructions
  function automatic bit rtype_op(input logic [5:0] fn, output logic [2:0] op, output logic [1:0] sa);
    sa = 2'b01;
    op = 3'b000;
    case (fn)
      6'h20: op = 3'b010;
      6'h22: op = 3'b110;
      6'h24: op = 3'b000;
      6'h25: op = 3'b001;
      6'h27: op = 3'b011;
      6'h2A: op = 3'b111;
      6'h00: begin op = 3'b100; sa = 2'b10; end
      6'h02: begin op = 3'b101; sa = 2'b10; end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Expected per-cycle outputs for one instruction, starting in the fetch cycle
  function automatic void build_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                                      input int fs, input int ms);
    bit legal;
    logic [2:0] aop;
    logic [1:0] sa;
    for (int i = 0; i < fs; i++) push(ov(1,0,0,0,0,0,0,1,3'b010,0,0,0,0,0), 1'b0);
    push(ov(1,0,0,1,1,0,0,1,3'b010,0,0,0,0,0), 1'b1);
    legal = (op == 6'h23) || (op == 6'h2B) || (op == 6'h00) || (op == 6'h04) ||
            (op == 6'h08) || (op == 6'h02) || (BNE && op == 6'h05);
    push(ov(0,0,0,0,0,0,0,3,3'b010,0,0,0,!legal,!legal), rnd_bit());
    if (!legal) return;
    case (op)
      6'h23: begin
        push(ov(0,0,0,0,0,0,1,2,3'b010,0,0,0,0,0), rnd_bit());
        for (int i = 0; i < ms; i++) push(ov(1,0,1,0,0,0,0,0,0,0,0,0,0,0), 1'b0);
        push(ov(1,0,1,0,0,0,0,0,0,0,0,0,0,0), 1'b1);
        push(ov(0,0,0,0,0,0,0,0,0,1,0,1,1,0), rnd_bit());
      end
      6'h2B: begin
        push(ov(0,0,0,0,0,0,1,2,3'b010,0,0,0,0,0), rnd_bit());
        for (int i = 0; i < ms; i++) push(ov(0,1,1,0,0,0,0,0,0,0,0,0,0,0), 1'b0);
        push(ov(0,1,1,0,0,0,0,0,0,0,0,0,1,0), 1'b1);
      end
      6'h00: begin
        if (rtype_op(fn, aop, sa)) begin
          push(ov(0,0,0,0,0,0,sa,0,aop,0,0,0,0,0), rnd_bit());
          push(ov(0,0,0,0,0,0,sa,0,aop,1,1,0,1,0), rnd_bit());
        end else begin
          push(ov(0,0,0,0,0,0,1,0,3'b000,0,0,0,1,1), rnd_bit());
        end
      end
      6'h04, 6'h05: push(ov(0,0,0,0,z ^ (op == 6'h05),1,1,0,3'b110,0,0,0,1,0), rnd_bit());
      6'h08: begin
        push(ov(0,0,0,0,0,0,1,2,3'b010,0,0,0,0,0), rnd_bit());
        push(ov(0,0,0,0,0,0,0,0,0,1,0,0,1,0), rnd_bit());
      end
      default: push(ov(0,0,0,0,1,2,0,0,0,0,0,0,1,0), rnd_bit());
    endcase
  endfunction

  function automatic void clear_model();
    exp_q.delete();
    mr_q.delete();
    obs_q.delete();
  endfunction

  // Drives mem_ready per cycle and records outputs at the falling edge; entered at posedge+1
  task automatic drive(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ready = mr_q[i];
      @(negedge clk);
      obs_q.push_back(obs_vec);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs_vec !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_hold got %b exp %b", obs_vec, 19'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs_vec !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_idle got %b exp %b", obs_vec, 19'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_rtype_add();
    clear_model();
    opcode = 6'h00; funct = 6'h20; is_zero = 1'b0;
    build_instr(opcode, funct, is_zero, 0, 0);
    drive(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rtype_add cycle %0d got %b exp %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_shift_illegal();
    clear_model();
    opcode = 6'h00; funct = 6'h00;
    build_instr(6'h00, 6'h00, 1'b0, 1, 0);
    drive(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL sll cycle %0d got %b exp %b", i, obs_q[i], exp_q[i]);
      end
    end
    clear_model();
    funct = 6'h3F;
    build_instr(6'h00, 6'h3F, 1'b0, 0, 0);
    drive(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bad_funct cycle %0d got %b exp %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_lw_stall();
    clear_model();
    opcode = 6'h23; funct = 6'h11;
    build_instr(opcode, funct, 1'b0, 0, 3);
    drive(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL lw_stall cycle %0d got %b exp %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops[3] = '{6'h04, 6'h04, 6'h05};
    bit         zs[3]  = '{1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      clear_model();
      opcode = ops[k]; is_zero = zs[k];
      build_instr(ops[k], funct, zs[k], 0, 0);
      drive(exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL branch%0d cycle %0d got %b exp %b", k, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] op_tab[10] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02, 6'h0F, 6'h3F};
    logic [5:0] fn_tab[10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h3F, 6'h01};
    for (int n = 0; n < 80; n++) begin
      clear_model();
      opcode  = op_tab[$urandom_range(0, 9)];
      funct   = fn_tab[$urandom_range(0, 9)];
      is_zero = rnd_bit();
      build_instr(opcode, funct, is_zero, $urandom_range(0, 2), $urandom_range(0, 3));
      drive(exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random n=%0d op=%h fn=%h cycle %0d got %b exp %b",
                   n, opcode, funct, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midstall();
    clear_model();
    opcode = 6'h2B; funct = 6'h00;
    build_instr(opcode, funct, 1'b0, 0, 5);
    drive(5);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL sw_pre_reset cycle %0d got %b exp %b", i, obs_q[i], exp_q[i]);
      end
    end
    mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_stall_mem_write got %b exp 1", mem_write);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs_vec !== 19'd0) begin
      n_fail++;
      $display("FAIL async_reset_drop got %b exp %b", obs_vec, 19'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs_vec !== 19'd0) begin
      n_fail++;
      $display("FAIL restart_idle got %b exp %b", obs_vec, 19'd0);
    end
    @(posedge clk);
    #1;
    clear_model();
    opcode = 6'h08;
    build_instr(opcode, funct, 1'b0, 1, 0);
    drive(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL restart_addi cycle %0d got %b exp %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_shift_illegal();
    test_lw_stall();
    test_branch();
    test_random();
    test_reset_midstall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
